// File: rtl/mips_pkg.sv
// Shared definitions for the program loader: host commands, loader FSM
// states and the header word layout.
package mips_pkg;

  // Host command codes carried in the header's top two bits
  localparam logic [1:0] CMD_LOAD_I = 2'b00;
  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_HALT   = 2'b10;
  localparam logic [1:0] CMD_START  = 2'b11;

  // Header layout: [31:30] cmd, [29:16] base word index, [15:0] word count
  localparam int HDR_CMD_LSB  = 30;
  localparam int HDR_BASE_LSB = 16;
  localparam int HDR_BASE_W   = 14;
  localparam int HDR_CNT_LSB  = 0;
  localparam int HDR_CNT_W    = 16;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_I_DATA = 3'd1,
    LD_D_WORD = 3'd2,
    LD_D_BYTE = 3'd3,
    LD_RF_CLR = 3'd4
  } ld_state_e;

  function automatic logic [1:0] hdr_cmd(input logic [31:0] h);
    return h[HDR_CMD_LSB +: 2];
  endfunction

  function automatic logic [HDR_BASE_W-1:0] hdr_base(input logic [31:0] h);
    return h[HDR_BASE_LSB +: HDR_BASE_W];
  endfunction

  function automatic logic [HDR_CNT_W-1:0] hdr_cnt(input logic [31:0] h);
    return h[HDR_CNT_LSB +: HDR_CNT_W];
  endfunction

endpackage

// File: rtl/ldr_byte_serializer.sv
// Splits a latched 32-bit word into four bytes, least significant first.
// idx is the index of the byte currently presented on byte_out; done pulses
// in the cycle the last byte is consumed.
module ldr_byte_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] word,
  output logic [7:0]  byte_out,
  output logic [1:0]  idx,
  output logic        done
);

  logic [31:0] shreg;

  // Latch a new word, or shift right by one byte per step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= word;
      idx   <= '0;
    end else if (step) begin
      shreg <= {8'h00, shreg[31:8]};
      idx   <= idx + 2'd1;
    end
  end

  assign byte_out = shreg[7:0];
  assign done     = step && (idx == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Stream-driven loader for the MIPS core's instruction/data memories.
// Handshake: a word moves from host to loader on every rising clk edge
// where in_valid && in_ready; in_ready does not depend on in_valid.
// All memory/regfile strobes are registered, so a write appears the cycle
// after the transfer or serializer step that produced it.
module prog_loader import mips_pkg::*; #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_BYTES = 32,
  parameter int RF_REGS    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [31:0]                   in_data,
  output logic                          in_ready,
  output logic                          imem_we,
  output logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
  output logic [31:0]                   imem_wdata,
  output logic                          dmem_we,
  output logic [$clog2(DMEM_BYTES)-1:0] dmem_addr,
  output logic [7:0]                    dmem_wdata,
  output logic                          rf_we,
  output logic [4:0]                    rf_waddr,
  output logic [31:0]                   rf_wdata,
  output logic                          cpu_run,
  output logic                          busy,
  output logic                          err,
  output ld_state_e                     dbg_state
);

  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_BYTES);
  // Word address is wide enough that base + count never wraps back into range
  localparam logic [16:0] IMEM_LIM = 17'(IMEM_WORDS);
  localparam logic [18:0] DMEM_LIM = 19'(DMEM_BYTES);
  localparam logic [4:0]  RF_LAST  = 5'(RF_REGS - 1);

  ld_state_e   state, state_nxt;
  logic [16:0] addr;
  logic [15:0] remaining;
  logic [4:0]  rf_cnt;
  logic        xfer;
  logic        ser_load, ser_step, ser_done;
  logic [7:0]  ser_byte;
  logic [1:0]  ser_idx;
  logic [18:0] byte_addr;

  assign byte_addr = {addr, 2'b00} + {17'b0, ser_idx};
  assign busy      = (state != LD_IDLE);
  assign rf_wdata  = 32'h0;
  assign dbg_state = state;

  ldr_byte_serializer u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (ser_load),
    .step     (ser_step),
    .word     (in_data),
    .byte_out (ser_byte),
    .idx      (ser_idx),
    .done     (ser_done)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LD_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake/serializer control
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ser_load  = 1'b0;
    ser_step  = 1'b0;
    case (state)
      LD_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          case (hdr_cmd(in_data))
            CMD_LOAD_I: if (hdr_cnt(in_data) != '0) state_nxt = LD_I_DATA;
            CMD_LOAD_D: if (hdr_cnt(in_data) != '0) state_nxt = LD_D_WORD;
            CMD_START:  state_nxt = LD_RF_CLR;
            default:    state_nxt = LD_IDLE;
          endcase
        end
      end
      LD_I_DATA: begin
        in_ready = 1'b1;
        if (in_valid && remaining == 16'd1) state_nxt = LD_IDLE;
      end
      LD_D_WORD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ser_load  = 1'b1;
          state_nxt = LD_D_BYTE;
        end
      end
      LD_D_BYTE: begin
        ser_step = 1'b1;
        if (ser_done) state_nxt = (remaining == 16'd1) ? LD_IDLE : LD_D_WORD;
      end
      LD_RF_CLR: begin
        if (rf_cnt == RF_LAST) state_nxt = LD_IDLE;
      end
      default: state_nxt = LD_IDLE;
    endcase
    xfer = in_valid && in_ready;
  end

  // Counters, registered write strobes, run enable and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      remaining  <= '0;
      rf_cnt     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      cpu_run    <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      rf_we   <= 1'b0;
      case (state)
        LD_IDLE: begin
          if (xfer) begin
            case (hdr_cmd(in_data))
              CMD_LOAD_I, CMD_LOAD_D: begin
                cpu_run   <= 1'b0;
                addr      <= 17'(hdr_base(in_data));
                remaining <= hdr_cnt(in_data);
              end
              CMD_HALT:  cpu_run <= 1'b0;
              default:   rf_cnt  <= '0;
            endcase
          end
        end
        LD_I_DATA: begin
          if (xfer) begin
            if (addr < IMEM_LIM) begin
              imem_we    <= 1'b1;
              imem_addr  <= addr[IA-1:0];
              imem_wdata <= in_data;
            end else begin
              err <= 1'b1;
            end
            addr      <= addr + 17'd1;
            remaining <= remaining - 16'd1;
          end
        end
        LD_D_BYTE: begin
          if (byte_addr < DMEM_LIM) begin
            dmem_we    <= 1'b1;
            dmem_addr  <= byte_addr[DA-1:0];
            dmem_wdata <= ser_byte;
          end else begin
            err <= 1'b1;
          end
          if (ser_done) begin
            addr      <= addr + 17'd1;
            remaining <= remaining - 16'd1;
          end
        end
        LD_RF_CLR: begin
          rf_we    <= 1'b1;
          rf_waddr <= rf_cnt;
          rf_cnt   <= rf_cnt + 5'd1;
          if (rf_cnt == RF_LAST) cpu_run <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed + randomized bench for prog_loader. A reference model turns each
// command into the list of memory/regfile writes it should cause; a monitor
// matches every observed strobe against that list in order.
module tb_prog_loader;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        dmem_we;
  logic [4:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        cpu_run;
  logic        busy;
  logic        err;
  ld_state_e   dbg_state;

  prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .cpu_run    (cpu_run),
    .busy       (busy),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / global watchdog ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  // event = {kind[1:0] (0 imem, 1 dmem, 2 rf), addr[7:0], data[31:0]}
  logic [41:0] exp_q[$];
  logic [31:0] wq[$];
  logic [31:0] imem_model [64];
  logic [31:0] dut_imem   [64];
  logic        err_exp = 1'b0;
  logic        cpu_run_exp = 1'b0;
  int          n_imem = 0, n_dmem = 0, n_rf = 0;
  logic [41:0] mon_obs, mon_exp;

  function automatic logic [41:0] ev(input logic [1:0] k, input int a, input logic [31:0] d);
    return {k, 8'(a), d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (imem_we || dmem_we || rf_we) begin
      chk("strobe_onehot", $onehot({imem_we, dmem_we, rf_we}), 1);
      if (imem_we) begin
        mon_obs = ev(2'd0, int'(imem_addr), imem_wdata);
        dut_imem[imem_addr] = imem_wdata;
        n_imem++;
      end else if (dmem_we) begin
        mon_obs = ev(2'd1, int'(dmem_addr), {24'h0, dmem_wdata});
        n_dmem++;
      end else begin
        mon_obs = ev(2'd2, int'(rf_waddr), rf_wdata);
        n_rf++;
      end
      mon_exp = (exp_q.size() == 0) ? '1 : exp_q.pop_front();
      chk("write_event", 64'(mon_obs), 64'(mon_exp));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] w);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("send_timeout", 64'(t < 100), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  // LOAD_I of the words in wq at word index base, with gap idle cycles between words
  task automatic load_i(input int base, input int gap);
    send_word({CMD_LOAD_I, 14'(base), 16'(wq.size())});
    cpu_run_exp = 1'b0;
    for (int i = 0; i < wq.size(); i++) begin
      if (base + i < 64) begin
        exp_q.push_back(ev(2'd0, base + i, wq[i]));
        imem_model[base + i] = wq[i];
      end else begin
        err_exp = 1'b1;
      end
      send_word(wq[i]);
      repeat (gap) @(negedge clk);
    end
  endtask

  // LOAD_D of the words in wq at word index base; bytes land little-endian
  task automatic load_d(input int base, input int gap);
    logic [31:0] w;
    send_word({CMD_LOAD_D, 14'(base), 16'(wq.size())});
    cpu_run_exp = 1'b0;
    for (int i = 0; i < wq.size(); i++) begin
      w = wq[i];
      for (int j = 0; j < 4; j++) begin
        if ((base + i) * 4 + j < 32) exp_q.push_back(ev(2'd1, (base + i) * 4 + j, {24'h0, w[8*j +: 8]}));
        else                         err_exp = 1'b1;
      end
      send_word(w);
      repeat (gap) @(negedge clk);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n0, run, maxrun, cnt;
    for (int i = 0; i < 64; i++) begin
      imem_model[i] = '0;
      dut_imem[i]   = '0;
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {imem_we, dmem_we, rf_we, cpu_run, busy, err}, 0);
    chk("reset_addrs", {imem_addr, dmem_addr, rf_waddr, imem_wdata, dmem_wdata}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);

    // 1: three instruction words at imem[0..2]
    n0 = n_imem;
    wq = '{32'h20100005, 32'h2011000A, 32'h02328020};
    load_i(0, 0);
    chk("t1_busy_after_last", busy, 0);
    repeat (2) @(negedge clk);
    chk("t1_imem_strobes", 64'(n_imem - n0), 3);
    chk("t1_cpu_run", cpu_run, 0);

    // 2: one data word at word 1 -> bytes 4..7
    n0 = n_dmem;
    wq = '{32'h11223344};
    load_d(1, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!in_ready) cnt++;
    end
    chk("t2_ready_low_cycles", 64'(cnt), 4);
    chk("t2_dmem_strobes", 64'(n_dmem - n0), 4);
    chk("t2_err", err, 0);

    // 3: START clears the register file then runs; HALT stops
    for (int i = 0; i < 32; i++) exp_q.push_back(ev(2'd2, i, 32'h0));
    send_word(32'hC0000000);
    run = 0;
    maxrun = 0;
    n0 = n_rf;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rf_we) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    cpu_run_exp = 1'b1;
    chk("t3_rf_consecutive", 64'(maxrun), 32);
    chk("t3_busy", busy, 0);
    chk("t3_cpu_run", cpu_run, cpu_run_exp);
    send_word(32'h80000000);
    cpu_run_exp = 1'b0;
    chk("t3_halt", cpu_run, cpu_run_exp);

    // 6a: zero-length load does nothing
    send_word(32'h00000000);
    @(negedge clk);
    chk("t6_zero_ready", in_ready, 1);
    chk("t6_zero_busy", busy, 0);

    // 6b: same words back-to-back and with 3-cycle gaps
    wq = '{$urandom, $urandom, $urandom, $urandom};
    load_i(8, 0);
    wait_idle();
    load_i(16, 3);
    wait_idle();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("t6_b2b_word", dut_imem[8 + i], wq[i]);
      chk("t6_gap_word", dut_imem[16 + i], wq[i]);
    end

    // random loads, including some that run past the end of memory
    for (int k = 0; k < 10; k++) begin
      wq.delete();
      cnt = $urandom_range(1, 3);
      for (int i = 0; i < cnt; i++) wq.push_back($urandom);
      if ($urandom_range(0, 1) == 0) load_i($urandom_range(0, 66), $urandom_range(0, 2));
      else                           load_d($urandom_range(0, 9), $urandom_range(0, 2));
      wait_idle();
    end
    repeat (2) @(negedge clk);
    chk("rand_err", err, err_exp);
    chk("rand_cpu_run", cpu_run, cpu_run_exp);

    // 4: load that crosses the top of instruction memory
    n0 = n_imem;
    wq = '{$urandom, $urandom};
    load_i(63, 0);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("t4_imem_strobes", 64'(n_imem - n0), 1);
    chk("t4_err_set", err, 1);
    chk("t4_err_model", err, err_exp);
    repeat (3) @(negedge clk);
    chk("t4_err_sticky", err, 1);

    // 5: reset in the middle of the byte phase
    wq = '{$urandom};
    load_d(2, 0);
    n0 = n_dmem;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (n_dmem - n0 == 2) break;
    end
    chk("t5_reached_byte1", 64'(n_dmem - n0), 2);
    reset = 1'b1;
    #1;
    chk("t5_async_clear", {imem_we, dmem_we, rf_we, cpu_run, busy, err}, 0);
    chk("t5_abandoned_bytes", 64'(exp_q.size()), 2);
    exp_q.delete();
    err_exp = 1'b0;
    cpu_run_exp = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_more_dmem", 64'(n_dmem - n0), 2);
    n0 = n_imem;
    wq = '{$urandom};
    load_i(5, 0);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("t5_post_reset_load", 64'(n_imem - n0), 1);
    chk("t5_err_cleared", err, err_exp);

    // final: nothing outstanding, instruction memory image matches the model
    chk("exp_q_empty", 64'(exp_q.size()), 0);
    for (int i = 0; i < 64; i++) chk("imem_image", dut_imem[i], imem_model[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
